mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Controls the MEM stage of the 5-stage pipeline. It reads the control and data fields held in the EX/MEM pipeline register and runs each data-memory access over a req/ack handshake. While an access is outstanding it asserts stall so every pipeline register freezes. It also forms byte enables and store-lane replication, and aligns and extends load data for the MEM/WB register.

Parameters:
TIMEOUT, 16, maximum ACCESS cycles without mem_ack before bus_err; legal range 2..255
CNT_W, 8, width of the timeout counter; must be large enough to hold TIMEOUT

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  EX/MEM register holds a live instruction
flush  input  1  squash the current EX/MEM instruction; do not start its access
mem_wr  input  1  store instruction
mem_to_reg  input  1  load instruction
dsize  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved
load_ext  input  1  1 = sign-extend load, 0 = zero-extend
exec_result  input  32  effective address
busb  input  32  store data, right-justified
mem_req  output  1  memory request, registered
mem_we  output  1  write enable, registered
mem_addr  output  32  word address, {exec_result[31:2],2'b00}, registered
mem_be  output  4  byte enables, registered
mem_wdata  output  32  lane-replicated store data, registered
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  access complete
stall  output  1  freeze all pipeline registers, combinational
load_data  output  32  aligned and extended load result
load_valid  output  1  load_data valid, one cycle
misalign_exc  output  1  alignment or reserved-size fault, one cycle
bus_err  output  1  timeout fault, one cycle

Behaviour:
- Reset: state IDLE. mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data, load_valid, misalign_exc, bus_err and the counter are all 0.
- Reset asserted mid-access drops mem_req immediately. Any ack arriving afterwards is ignored.
- start = state==IDLE & in_valid & ~flush & (mem_wr | mem_to_reg) & aligned.
- If mem_wr and mem_to_reg are both 1, the instruction is treated as a store.
- Alignment: a word needs addr[1:0]==00. A halfword needs addr[0]==0. A byte is always aligned. dsize 11 is always misaligned.
- In IDLE, a valid, unflushed memory instruction that is misaligned pulses misalign_exc the next cycle. No request is issued, there is no stall, and the instruction advances.
- stall = start | (state==ACCESS). It is 0 in DONE and 0 in IDLE otherwise.
- FSM IDLE -> ACCESS on start. Registers loaded on that transition:
  - mem_req=1, mem_we=mem_wr, mem_addr, counter=1.
  - mem_be: word 1111; halfword 0011 when addr[1]=0, 1100 when addr[1]=1; byte 0001<<addr[1:0] (little-endian).
  - mem_wdata: word busb; halfword {2{busb[15:0]}}; byte {4{busb[7:0]}}.
  - Latched state for extraction: dsize, load_ext, addr[1:0], is_load.
- ACCESS: mem_req and all request fields are held stable.
  - mem_ack=1: go to DONE and deassert mem_req. For a load, capture load_data.
  - Load extraction: select the lane by addr[1:0], then extend per load_ext.
  - No ack with counter==TIMEOUT: go to DONE and set an error flag.
  - Otherwise increment the counter.
- DONE (exactly 1 cycle): mem_req=0 and stall=0, so the pipeline advances.
  - load_valid=1 only for a load that completed without error.
  - bus_err=1 if the access timed out.
  - EX/MEM inputs are ignored in this cycle; they still describe the completed instruction.
  - Next state IDLE.
- Minimum access: IDLE (stall) -> ACCESS with ack in the first request cycle -> DONE. That is 2 stall cycles, with load_valid in cycle 3.
- A flush during ACCESS does not abort the access; the operation completes normally.
- A mem_ack seen outside ACCESS is ignored.
- load_data holds its last value until the next load capture.

Test Plan:
- Word load, addr 0x8, mem_rdata 0xDEADBEEF, ack in first ACCESS cycle -> mem_be=1111, mem_addr=0x8, stall high 2 cycles, load_valid=1 with load_data=0xDEADBEEF.
- Byte load, sign-extend, addr 0x13, mem_rdata 0x80123456, ack after 3 cycles -> mem_be=1000, load_data=0xFFFFFF80. Repeat with load_ext=0 -> 0x00000080.
- Halfword store, addr 0x22, busb 0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, load_valid stays 0.
- Halfword at addr 0x21, and a word with dsize=11 -> misalign_exc pulses 1 cycle, mem_req never rises, stall stays 0.
- TIMEOUT=4 with no ack -> mem_req high 4 cycles, then bus_err=1 for 1 cycle, stall drops, FSM returns to IDLE.
- Reset asserted on the second ACCESS cycle, with ack arriving after reset is released -> mem_req=0 asynchronously, all outputs 0, no load_valid.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs one data-memory access per load/store over a
// req/ack handshake, freezes the pipeline while the access is outstanding,
// builds byte enables / replicated store data, and aligns and extends loads.
//
// Handshake: mem_req rises on the cycle after a legal access is accepted and
// stays high with mem_we/mem_addr/mem_be/mem_wdata held stable until the
// first cycle mem_ack is sampled high (or the timeout expires). mem_ack is
// only honoured while the FSM is in ACCESS; it is ignored at all other times.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        flush,
    input  logic        mem_wr,
    input  logic        mem_to_reg,
    input  logic [1:0]  dsize,
    input  logic        load_ext,
    input  logic [31:0] exec_result,
    input  logic [31:0] busb,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             ext_q;
    logic             is_load_q;

    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;
    logic [31:0]      load_data_q;
    logic             load_valid_q;
    logic             misalign_q;
    logic             bus_err_q;

    logic             is_mem;
    logic             aligned;
    logic             req_ok;
    logic             start;
    logic             misalign;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [31:0]      load_d;

    // A store wins when both mem_wr and mem_to_reg are set.
    assign is_mem   = mem_wr | mem_to_reg;
    assign req_ok   = (state_q == IDLE) & in_valid & ~flush & is_mem;
    assign start    = req_ok & aligned;
    assign misalign = req_ok & ~aligned;
    assign stall    = start | (state_q == ACCESS);

    // Natural alignment check; the reserved size never aligns.
    always_comb begin
        aligned = 1'b0;
        case (dsize)
            2'b00:   aligned = (exec_result[1:0] == 2'b00);
            2'b01:   aligned = ~exec_result[0];
            2'b10:   aligned = 1'b1;
            default: aligned = 1'b0;
        endcase
    end

    // Little-endian byte enables and lane-replicated store data.
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = busb;
        case (dsize)
            2'b00: begin
                be_d    = 4'b1111;
                wdata_d = busb;
            end
            2'b01: begin
                be_d    = exec_result[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{busb[15:0]}};
            end
            default: begin
                be_d    = 4'b0001 << exec_result[1:0];
                wdata_d = {4{busb[7:0]}};
            end
        endcase
    end

    // Pick the addressed lane of the read data and extend it to 32 bits.
    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (off_q)
            2'b00:   byte_lane = mem_rdata[7:0];
            2'b01:   byte_lane = mem_rdata[15:8];
            2'b10:   byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_d    = mem_rdata;
        case (size_q)
            2'b00:   load_d = mem_rdata;
            2'b01:   load_d = {{16{ext_q & half_lane[15]}}, half_lane};
            default: load_d = {{24{ext_q & byte_lane[7]}}, byte_lane};
        endcase
    end

    // Access FSM with registered request fields and one-cycle status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            ext_q        <= 1'b0;
            is_load_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'd0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= ACCESS;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= mem_wr;
                        mem_addr_q  <= {exec_result[31:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        cnt_q       <= CNT_W'(1);
                        size_q      <= dsize;
                        off_q       <= exec_result[1:0];
                        ext_q       <= load_ext;
                        is_load_q   <= mem_to_reg & ~mem_wr;
                    end else if (misalign) begin
                        misalign_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        if (is_load_q) begin
                            load_data_q  <= load_d;
                            load_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign load_data    = load_data_q;
    assign load_valid   = load_valid_q;
    assign misalign_exc = misalign_q;
    assign bus_err      = bus_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed accesses push expected requests, run
// lengths, load results and fault events into queues; a negedge monitor pops
// and compares whenever the DUT presents the corresponding output.
module tb_mem_stage_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        mem_wr;
  logic        mem_to_reg;
  logic [1:0]  dsize;
  logic        load_ext;
  logic [31:0] exec_result;
  logic [31:0] busb;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_exc;
  logic        bus_err;
  logic [1:0]  dbg_state;

  mem_stage_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .flush(flush),
    .mem_wr(mem_wr),
    .mem_to_reg(mem_to_reg),
    .dsize(dsize),
    .load_ext(load_ext),
    .exec_result(exec_result),
    .busb(busb),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .stall(stall),
    .load_data(load_data),
    .load_valid(load_valid),
    .misalign_exc(misalign_exc),
    .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // request entry: {we, addr[31:0], be[3:0], wdata[31:0]}
  logic [68:0] req_q[$];
  logic [7:0]  req_len_q[$];
  logic [7:0]  stall_len_q[$];
  logic [31:0] load_q[$];
  logic        evt_q[$];   // 0 = misalign_exc, 1 = bus_err

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  // ---------------- monitor ----------------
  logic        req_prev   = 1'b0;
  logic        stall_prev = 1'b0;
  int          req_run    = 0;
  int          stall_run  = 0;
  logic [68:0] cur_req    = '0;
  logic [68:0] exp_e;
  logic [7:0]  exp_len;
  logic [31:0] exp_ld;
  logic        exp_ev;

  always @(negedge clock) begin
    if (mem_req === 1'b1) begin
      if (!req_prev) begin
        if (req_q.size() == 0) unexpected("req_rise");
        else begin
          exp_e   = req_q.pop_front();
          cur_req = exp_e;
          check("req_fields", {mem_we, mem_addr, mem_be, mem_wdata}, exp_e);
        end
      end else begin
        check("req_stable", {mem_we, mem_addr, mem_be, mem_wdata}, cur_req);
      end
      req_run++;
    end else if (req_prev) begin
      if (req_len_q.size() == 0) unexpected("req_len");
      else begin
        exp_len = req_len_q.pop_front();
        check("req_len", 69'(req_run), 69'(exp_len));
      end
      req_run = 0;
    end
    req_prev = (mem_req === 1'b1);

    if (stall === 1'b1) begin
      stall_run++;
    end else if (stall_prev) begin
      if (stall_len_q.size() == 0) unexpected("stall_len");
      else begin
        exp_len = stall_len_q.pop_front();
        check("stall_len", 69'(stall_run), 69'(exp_len));
      end
      stall_run = 0;
    end
    stall_prev = (stall === 1'b1);

    if (load_valid === 1'b1) begin
      if (load_q.size() == 0) unexpected("load_valid");
      else begin
        exp_ld = load_q.pop_front();
        check("load_data", 69'(load_data), 69'(exp_ld));
      end
    end

    if (misalign_exc === 1'b1) begin
      if (evt_q.size() == 0) unexpected("misalign_exc");
      else begin
        exp_ev = evt_q.pop_front();
        check("evt_misalign", 69'(1'b0), 69'(exp_ev));
      end
    end
    if (bus_err === 1'b1) begin
      if (evt_q.size() == 0) unexpected("bus_err");
      else begin
        exp_ev = evt_q.pop_front();
        check("evt_bus_err", 69'(1'b1), 69'(exp_ev));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    in_valid    = 1'b0;
    flush       = 1'b0;
    mem_wr      = 1'b0;
    mem_to_reg  = 1'b0;
    dsize       = 2'b00;
    load_ext    = 1'b0;
    exec_result = 32'd0;
    busb        = 32'd0;
  endtask

  // ack_dly: ACCESS cycle index carrying mem_ack (0 = first), -1 = never.
  task automatic do_access(input logic wr, input logic rd, input logic [1:0] ds,
                           input logic ext, input logic [31:0] addr,
                           input logic [31:0] bv, input logic [31:0] rdv,
                           input int ack_dly, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_ld_v,
                           input logic flush_mid);
    int k;
    req_q.push_back({wr, addr & 32'hFFFF_FFFC, exp_be, exp_wd});
    if (ack_dly >= 0) begin
      req_len_q.push_back(8'(ack_dly + 1));
      stall_len_q.push_back(8'(ack_dly + 2));
      if (rd && !wr) load_q.push_back(exp_ld_v);
    end else begin
      req_len_q.push_back(8'(TB_TIMEOUT));
      stall_len_q.push_back(8'(TB_TIMEOUT + 1));
      evt_q.push_back(1'b1);
    end
    in_valid    = 1'b1;
    mem_wr      = wr;
    mem_to_reg  = rd;
    dsize       = ds;
    load_ext    = ext;
    exec_result = addr;
    busb        = bv;
    @(posedge clock); #1;
    k = 0;
    while (mem_req === 1'b1 && k < 300) begin
      mem_ack   = (k == ack_dly);
      mem_rdata = (k == ack_dly) ? rdv : 32'h5A5A_5A5A;
      flush     = flush_mid;
      @(posedge clock); #1;
      k++;
    end
    if (k >= 300) unexpected("access_cycle_budget");
    mem_ack = 1'b0;
    flush   = 1'b0;
    // DONE cycle: EX/MEM still holds the completed instruction.
    @(posedge clock); #1;
    clear_inputs();
    @(posedge clock); #1;
  endtask

  task automatic do_misalign(input logic wr, input logic rd, input logic [1:0] ds,
                             input logic [31:0] addr);
    evt_q.push_back(1'b0);
    in_valid    = 1'b1;
    mem_wr      = wr;
    mem_to_reg  = rd;
    dsize       = ds;
    exec_result = addr;
    busb        = 32'h1111_2222;
    @(posedge clock); #1;
    clear_inputs();
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    reset     = 1'b1;
    #1;
    check("rst_mem_req", 69'(mem_req), 69'(0));
    check("rst_mem_we", 69'(mem_we), 69'(0));
    check("rst_mem_addr", 69'(mem_addr), 69'(0));
    check("rst_mem_be", 69'(mem_be), 69'(0));
    check("rst_mem_wdata", 69'(mem_wdata), 69'(0));
    check("rst_load_data", 69'(load_data), 69'(0));
    check("rst_load_valid", 69'(load_valid), 69'(0));
    check("rst_misalign", 69'(misalign_exc), 69'(0));
    check("rst_bus_err", 69'(bus_err), 69'(0));
    check("rst_stall", 69'(stall), 69'(0));
    check("rst_state", 69'(dbg_state), 69'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // word load, ack in first ACCESS cycle
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0008, 32'h1122_3344, 32'hDEAD_BEEF, 0,
              4'b1111, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0);
    // byte load sign-extended, ack on third ACCESS cycle
    do_access(1'b0, 1'b1, 2'b10, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'h8012_3456, 2,
              4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 1'b0);
    // same zero-extended, with a flush raised during ACCESS (must not abort)
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h8012_3456, 2,
              4'b1000, 32'h0000_0000, 32'h0000_0080, 1'b1);
    // halfword store at upper half
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 32'h0, 1,
              4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
    // halfword load at upper half, sign-extended
    do_access(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0002, 32'h0000_0000, 32'h8001_1234, 0,
              4'b1100, 32'h0000_0000, 32'hFFFF_8001, 1'b0);
    // byte load lane 1, zero-extended
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_AB00, 0,
              4'b0010, 32'h0000_0000, 32'h0000_00AB, 1'b0);
    // mem_wr and mem_to_reg both set: a word store, no load result
    do_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1,
              4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
    check("load_data_hold", 69'(load_data), 69'(32'h0000_00AB));
    // byte store lane 3
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0003, 32'h1234_5677, 32'h0, 0,
              4'b1000, 32'h7777_7777, 32'h0, 1'b0);

    // misaligned halfword and reserved size
    do_misalign(1'b0, 1'b1, 2'b01, 32'h0000_0021);
    do_misalign(1'b0, 1'b1, 2'b11, 32'h0000_0008);

    // flushed instruction: nothing starts
    in_valid = 1'b1; flush = 1'b1; mem_to_reg = 1'b1; exec_result = 32'h10;
    @(posedge clock); #1;
    clear_inputs();
    // ack outside ACCESS: ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(posedge clock); #1;
    check("idle_state", 69'(dbg_state), 69'(0));

    // timeout with no ack
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0080, 32'h0, 32'h0, -1,
              4'b1111, 32'h0, 32'h0, 1'b0);
    check("after_timeout_state", 69'(dbg_state), 69'(0));

    // reset during the second ACCESS cycle, ack after release
    req_q.push_back({1'b0, 32'h0000_0100, 4'b1111, 32'h0BAD_F00D});
    req_len_q.push_back(8'd1);
    stall_len_q.push_back(8'd2);
    in_valid = 1'b1; mem_to_reg = 1'b1; dsize = 2'b00;
    exec_result = 32'h0000_0100; busb = 32'h0BAD_F00D;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    clear_inputs();
    #1;
    check("arst_mem_req", 69'(mem_req), 69'(0));
    check("arst_mem_addr", 69'(mem_addr), 69'(0));
    check("arst_mem_be", 69'(mem_be), 69'(0));
    check("arst_mem_wdata", 69'(mem_wdata), 69'(0));
    check("arst_load_data", 69'(load_data), 69'(0));
    check("arst_stall", 69'(stall), 69'(0));
    check("arst_state", 69'(dbg_state), 69'(0));
    @(posedge clock); #1;
    reset   = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("post_rst_state", 69'(dbg_state), 69'(0));
    check("post_rst_load_data", 69'(load_data), 69'(0));

    repeat (2) @(posedge clock);
    #1;
    check("req_q_empty", 69'(req_q.size()), 69'(0));
    check("req_len_q_empty", 69'(req_len_q.size()), 69'(0));
    check("stall_len_q_empty", 69'(stall_len_q.size()), 69'(0));
    check("load_q_empty", 69'(load_q.size()), 69'(0));
    check("evt_q_empty", 69'(evt_q.size()), 69'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
